// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle for alu_seq.
// The master drives requests and accepts results; the slave is the ALU.
interface alu_seq_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int OPCODE_BITS     = 5,
    parameter int PARAM_BITS      = 8,
    parameter int NUM_STATUS_BITS = 3
) ();
    logic                       in_valid;
    logic                       in_ready;
    logic [OPCODE_BITS-1:0]     opcode;
    logic [DATA_WIDTH-1:0]      operand1;
    logic [DATA_WIDTH-1:0]      operand2;
    logic [PARAM_BITS-1:0]      param;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_WIDTH-1:0]      result;
    logic [NUM_STATUS_BITS-1:0] status;
    logic                       busy;

    modport master (
        output in_valid,
        output opcode,
        output operand1,
        output operand2,
        output param,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  status,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  opcode,
        input  operand1,
        input  operand2,
        input  param,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output status,
        output busy
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU for the Jac1-8 datapath.
// One op per handshake; MUL runs one shift-add step per cycle.
module alu_seq #(
    parameter int DATA_WIDTH      = 8,
    parameter int OPCODE_BITS     = 5,
    parameter int PARAM_BITS      = 8,
    parameter int NUM_STATUS_BITS = 3
) (
    input  logic     clk,
    input  logic     reset_n,
    alu_seq_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam int SB = NUM_STATUS_BITS;
    localparam logic [31:0] WU = 32'(DATA_WIDTH);

    localparam logic [OPCODE_BITS-1:0] OP_ADD = OPCODE_BITS'(1);
    localparam logic [OPCODE_BITS-1:0] OP_SUB = OPCODE_BITS'(2);
    localparam logic [OPCODE_BITS-1:0] OP_AND = OPCODE_BITS'(3);
    localparam logic [OPCODE_BITS-1:0] OP_OR  = OPCODE_BITS'(4);
    localparam logic [OPCODE_BITS-1:0] OP_NOT = OPCODE_BITS'(5);
    localparam logic [OPCODE_BITS-1:0] OP_XOR = OPCODE_BITS'(6);
    localparam logic [OPCODE_BITS-1:0] OP_SHL = OPCODE_BITS'(7);
    localparam logic [OPCODE_BITS-1:0] OP_SHR = OPCODE_BITS'(8);
    localparam logic [OPCODE_BITS-1:0] OP_VAL = OPCODE_BITS'(9);
    localparam logic [OPCODE_BITS-1:0] OP_MUL = OPCODE_BITS'(10);
    localparam logic [OPCODE_BITS-1:0] OP_ROL = OPCODE_BITS'(11);
    localparam logic [OPCODE_BITS-1:0] OP_ROR = OPCODE_BITS'(12);
    localparam logic [OPCODE_BITS-1:0] OP_ADC = OPCODE_BITS'(13);
    localparam logic [OPCODE_BITS-1:0] OP_SBB = OPCODE_BITS'(14);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic ready;
    logic accept;
    logic is_mul;
    logic last;

    logic [W-1:0]  op1;
    logic [W-1:0]  op2;
    logic          cin;
    logic          bin;
    logic [W:0]    sum_w;
    logic [W:0]    diff_w;
    logic [31:0]   sh_amt;
    logic [31:0]   rot_amt;
    logic [W-1:0]  shl_v;
    logic [W-1:0]  shr_v;
    logic [W-1:0]  rol_v;
    logic [W-1:0]  ror_v;
    logic [W-1:0]  val_v;

    logic [W-1:0]  res_d;
    logic [SB-1:0] status_d;
    logic          c_d;
    logic          b_d;
    logic          z_d;
    logic          carry_d;

    logic          carry_q;
    logic [W-1:0]  result_q;
    logic [SB-1:0] status_q;

    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] acc_nxt;
    logic [SB-1:0]  mul_status;

    assign op1 = bus.operand1;
    assign op2 = bus.operand2;

    // carry_q doubles as the borrow for SBB
    assign cin = (bus.opcode == OP_ADC) & carry_q;
    assign bin = (bus.opcode == OP_SBB) & carry_q;

    assign sum_w  = {1'b0, op1} + {1'b0, op2}
                  + {{W{1'b0}}, cin};
    assign diff_w = {1'b0, op1} - {1'b0, op2}
                  - {{W{1'b0}}, bin};

    assign sh_amt  = 32'(bus.param);
    assign rot_amt = sh_amt % WU;

    assign shl_v = (sh_amt >= WU) ? '0 : (op1 << sh_amt);
    assign shr_v = (sh_amt >= WU) ? '0 : (op1 >> sh_amt);

    // a zero rotate shifts the other half by W, which yields 0
    assign rol_v = (op1 << rot_amt)
                 | (op1 >> (WU - rot_amt));
    assign ror_v = (op1 >> rot_amt)
                 | (op1 << (WU - rot_amt));

    generate
        if (PARAM_BITS >= DATA_WIDTH) begin : g_val_trunc
            assign val_v = bus.param[DATA_WIDTH-1:0];
        end else begin : g_val_ext
            assign val_v = {{(DATA_WIDTH-PARAM_BITS){1'b0}},
                            bus.param};
        end
    endgenerate

    always_comb begin
        res_d    = '0;
        c_d      = 1'b0;
        b_d      = 1'b0;
        z_d      = 1'b0;
        carry_d  = carry_q;
        is_mul   = 1'b0;
        status_d = '0;
        unique case (bus.opcode)
            OP_ADD, OP_ADC: begin
                res_d   = sum_w[W-1:0];
                c_d     = sum_w[W];
                z_d     = ~|sum_w;
                carry_d = sum_w[W];
            end
            OP_SUB, OP_SBB: begin
                res_d   = diff_w[W-1:0];
                b_d     = diff_w[W];
                z_d     = ~|diff_w;
                carry_d = diff_w[W];
            end
            OP_AND: begin
                res_d = op1 & op2;
                z_d   = ~|res_d;
            end
            OP_OR: begin
                res_d = op1 | op2;
                z_d   = ~|res_d;
            end
            OP_NOT: begin
                res_d = ~op2;
                z_d   = ~|res_d;
            end
            OP_XOR: begin
                res_d = op1 ^ op2;
                z_d   = ~|res_d;
            end
            OP_SHL: begin
                res_d = shl_v;
                z_d   = ~|res_d;
            end
            OP_SHR: begin
                res_d = shr_v;
                z_d   = ~|res_d;
            end
            OP_VAL: begin
                res_d = val_v;
                z_d   = ~|res_d;
            end
            OP_ROL: begin
                res_d = rol_v;
                z_d   = ~|res_d;
            end
            OP_ROR: begin
                res_d = ror_v;
                z_d   = ~|res_d;
            end
            OP_MUL: begin
                is_mul = 1'b1;
            end
            default: begin
                res_d = '0;
            end
        endcase
        status_d[0] = c_d;
        status_d[1] = b_d;
        status_d[2] = z_d;
    end

    assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last    = (cnt_q == CW'(W - 1));

    always_comb begin
        mul_status    = '0;
        mul_status[0] = |acc_nxt[2*W-1:W];
        mul_status[2] = ~|acc_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready  = 1'b1;
                accept = bus.in_valid;
                if (accept) begin
                    state_d = is_mul ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ready  = bus.out_ready;
                accept = bus.in_valid & bus.out_ready;
                if (accept) begin
                    state_d = is_mul ? EXEC : DONE;
                end else if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            status_q <= '0;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (accept) begin
            if (is_mul) begin
                acc_q    <= '0;
                mcand_q  <= {{W{1'b0}}, op1};
                mplier_q <= op2;
                cnt_q    <= '0;
            end else begin
                result_q <= res_d;
                status_q <= status_d;
                carry_q  <= carry_d;
            end
        end else if (state_q == EXEC) begin
            acc_q    <= acc_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (last) begin
                result_q <= acc_nxt[W-1:0];
                status_q <= mul_status;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == EXEC);
    assign bus.result    = result_q;
    assign bus.status    = status_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq.
// Expected values are hand-computed for the 8-bit default build.
module tb_alu_seq;
    localparam logic [4:0] NOP = 5'h00;
    localparam logic [4:0] ADD = 5'h01;
    localparam logic [4:0] SUB = 5'h02;
    localparam logic [4:0] AND = 5'h03;
    localparam logic [4:0] OR  = 5'h04;
    localparam logic [4:0] NOT = 5'h05;
    localparam logic [4:0] XOR = 5'h06;
    localparam logic [4:0] SHL = 5'h07;
    localparam logic [4:0] SHR = 5'h08;
    localparam logic [4:0] VAL = 5'h09;
    localparam logic [4:0] MUL = 5'h0A;
    localparam logic [4:0] ROL = 5'h0B;
    localparam logic [4:0] ROR = 5'h0C;
    localparam logic [4:0] ADC = 5'h0D;
    localparam logic [4:0] SBB = 5'h0E;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_bad;

    alu_seq_if bus ();

    alu_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic send(input logic [4:0] op,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [7:0] p);
        int n;
        n = 0;
        @(negedge clk);
        bus.opcode   = op;
        bus.operand1 = a;
        bus.operand2 = b;
        bus.param    = p;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic alu1(input string tag,
                        input logic [4:0] op,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [7:0] p,
                        input logic [7:0] er,
                        input logic [2:0] es);
        send(op, a, b, p);
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_res"}, bus.result, er);
        chk({tag, "_st"}, bus.status, es);
    endtask

    task automatic mul(input string tag,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [7:0] er,
                       input logic [2:0] es);
        send(MUL, a, b, 8'h00);
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_busy"},
                {bus.busy, bus.out_valid}, 2'b10);
            @(posedge clk);
            #1;
        end
        chk({tag, "_done"},
            {bus.busy, bus.out_valid}, 2'b01);
        chk({tag, "_res"}, bus.result, er);
        chk({tag, "_st"}, bus.status, es);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        n_vec        = 0;
        n_bad        = 0;
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.opcode   = NOP;
        bus.operand1 = '0;
        bus.operand2 = '0;
        bus.param    = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_res", bus.result, 0);
        chk("rst_st", bus.status, 0);
        reset_n = 1'b1;

        alu1("add_c", ADD, 8'hFF, 8'h02, 0, 8'h01, 3'b001);
        alu1("adc", ADC, 8'h00, 8'h00, 0, 8'h01, 3'b000);
        alu1("sub_b", SUB, 8'd14, 8'd15, 0, 8'hFF, 3'b010);
        alu1("sbb", SBB, 8'd5, 8'd3, 0, 8'h01, 3'b000);
        alu1("sub_z", SUB, 8'd126, 8'd126, 0, 8'h00, 3'b100);
        alu1("add_wrap", ADD, 8'hFF, 8'h01, 0, 8'h00, 3'b001);
        alu1("or", OR, 8'h0F, 8'h30, 0, 8'h3F, 3'b000);
        alu1("adc_keep", ADC, 8'h00, 8'h00, 0, 8'h01, 3'b000);
        alu1("not", NOT, 8'h12, 8'hF0, 0, 8'h0F, 3'b000);
        alu1("nop", NOP, 8'h12, 8'h34, 0, 8'h00, 3'b000);
        alu1("undef", 5'h1F, 8'h12, 8'h34, 0, 8'h00, 3'b000);

        mul("mul_a", 8'd15, 8'd17, 8'hFF, 3'b000);
        mul("mul_ov", 8'd16, 8'd16, 8'h00, 3'b001);
        mul("mul_z", 8'd0, 8'd200, 8'h00, 3'b100);

        alu1("xor", XOR, 8'hAF, 8'h55, 0, 8'hFA, 3'b000);
        bus.out_ready = 1'b0;
        bus.opcode    = AND;
        bus.operand1  = 8'hCC;
        bus.operand2  = 8'h33;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("bp_ready", bus.in_ready, 0);
            chk("bp_hold", {bus.out_valid, bus.status,
                            bus.result}, {1'b1, 3'b000, 8'hFA});
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("and_valid", bus.out_valid, 1);
        chk("and_res", bus.result, 8'h00);
        chk("and_st", bus.status, 3'b100);

        alu1("shl", SHL, 8'hF6, 8'h00, 8'h33, 8'h00, 3'b100);
        alu1("shr", SHR, 8'h66, 8'h00, 8'h04, 8'h06, 3'b000);
        alu1("rol", ROL, 8'h96, 8'h00, 8'h09, 8'h2D, 3'b000);
        alu1("ror", ROR, 8'h01, 8'h00, 8'h01, 8'h80, 3'b000);
        alu1("val", VAL, 8'h00, 8'h00, 8'h5A, 8'h5A, 3'b000);

        alu1("add_ff", ADD, 8'hFF, 8'hFF, 0, 8'hFE, 3'b001);
        bus.out_ready = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_done", {bus.out_valid, bus.in_ready}, 2'b01);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        bus.out_ready = 1'b1;

        alu1("add_ff2", ADD, 8'hFF, 8'hFF, 0, 8'hFE, 3'b001);
        send(MUL, 8'd3, 8'd5, 8'h00);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mul", {bus.busy, bus.out_valid}, 2'b00);
        chk("rst_mul_res", bus.result, 8'h00);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        alu1("adc_clr", ADC, 8'h00, 8'h00, 0, 8'h00, 3'b100);
        alu1("add_post", ADD, 8'd1, 8'd3, 0, 8'h04, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule
